// File: rtl/move_sequencer.sv
// Conditions raw button levels into one clamped (x,y) move per turn and pulses the active player's enable.
// Optional macro TURN_TIMEOUT_EN adds a forced commit after TIMEOUT_CYCLES idle cycles in COLLECT.
module move_sequencer #(
  parameter int MAX_STEP       = 3,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_confirm,
  input  logic       btn_clear,
  output logic [4:0] xMove,
  output logic [4:0] yMove,
  output logic       en0,
  output logic       en1,
  output logic       turn,
  output logic       busy,
  output logic [7:0] turn_count,
  output logic       timed_out
);

  typedef enum logic [1:0] {S_COLLECT, S_ISSUE, S_SETTLE} state_t;

  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_CONFIRM = 4, B_CLEAR = 5;
  localparam logic signed [4:0] LP_MAX = 5'(MAX_STEP);
  localparam logic signed [4:0] LP_MIN = -LP_MAX;

  state_t            r_state, w_state_nxt;
  logic [5:0]        r_sync1, r_sync2, r_prev;
  logic [5:0]        w_btn, w_edge;
  logic signed [4:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic              r_turn;
  logic [7:0]        r_count;
  logic              w_force;
  logic              w_commit;

  assign w_btn = {btn_clear, btn_confirm, btn_right, btn_left, btn_down, btn_up};

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_prev;

  // Saturating +/-1 step; opposing edges in one cycle cancel.
  function automatic logic signed [4:0] step_axis(input logic signed [4:0] v,
                                                  input logic inc, input logic dec);
    logic signed [4:0] res;
    res = v;
    if (inc && !dec && (v < LP_MAX)) res = v + 5'sd1;
    if (dec && !inc && (v > LP_MIN)) res = v - 5'sd1;
    return res;
  endfunction

  assign w_x_nxt = step_axis(r_x, w_edge[B_RIGHT], w_edge[B_LEFT]);
  assign w_y_nxt = step_axis(r_y, w_edge[B_DOWN],  w_edge[B_UP]);

`ifdef TURN_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] r_cnt;
  logic          r_timed_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_timed_out <= 1'b0;
    end else begin
      r_cnt       <= (r_state == S_COLLECT) ? r_cnt + 1'b1 : '0;
      r_timed_out <= w_force && !w_edge[B_CONFIRM];
    end
  end

  assign w_force   = (r_state == S_COLLECT) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timed_out = r_timed_out;
`else
  assign w_force   = 1'b0;
  assign timed_out = 1'b0;
`endif

  assign w_commit = (r_state == S_COLLECT) && (w_edge[B_CONFIRM] || w_force);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_COLLECT;
    else      r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: if (w_commit) w_state_nxt = S_ISSUE;
      S_ISSUE:   w_state_nxt = S_SETTLE;
      S_SETTLE:  w_state_nxt = S_COLLECT;
      default:   w_state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_turn  <= 1'b0;
      r_count <= '0;
    end else if (r_state == S_COLLECT && !w_commit) begin
      if (w_edge[B_CLEAR]) begin
        r_x <= '0;
        r_y <= '0;
      end else begin
        r_x <= w_x_nxt;
        r_y <= w_y_nxt;
      end
    end else if (r_state == S_SETTLE) begin
      r_x     <= '0;
      r_y     <= '0;
      r_turn  <= ~r_turn;
      r_count <= r_count + 8'd1;
    end
  end

  // Enables decode directly from the state flop so reset drops them asynchronously.
  assign en0        = (r_state == S_ISSUE) && !r_turn;
  assign en1        = (r_state == S_ISSUE) &&  r_turn;
  assign busy       = (r_state != S_COLLECT);
  assign xMove      = r_x;
  assign yMove      = r_y;
  assign turn       = r_turn;
  assign turn_count = r_count;

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: directed scenarios plus randomized turns
// compared against an integer-arithmetic model of the committed move.
`timescale 1ns/1ps
module tb_move_sequencer;

  localparam int MAX_STEP = 3;
`ifdef TURN_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 1000000;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_confirm = 0, btn_clear = 0;
  logic [4:0] xMove, yMove;
  logic       en0, en1, turn, busy, timed_out;
  logic [7:0] turn_count;

  move_sequencer #(.MAX_STEP(MAX_STEP), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_confirm(btn_confirm), .btn_clear(btn_clear),
    .xMove(xMove), .yMove(yMove), .en0(en0), .en1(en1), .turn(turn), .busy(busy),
    .turn_count(turn_count), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Model: the vector as plain integers, plus turn bookkeeping.
  int mx = 0, my = 0, mcount = 0;
  bit mturn = 0;

  // Enable monitor sampled on the falling edge.
  int         n_en0 = 0, n_en1 = 0, n_both = 0;
  logic [4:0] cap_x, cap_y;
  logic       cap_to, cap_busy;
  always @(negedge clk) begin
    if (en0 || en1) begin
      cap_x = xMove; cap_y = yMove; cap_to = timed_out; cap_busy = busy;
    end
    if (en0) n_en0++;
    if (en1) n_en1++;
    if (en0 && en1) n_both++;
  end

  function automatic int clamp(input int v);
    if (v > MAX_STEP)  return MAX_STEP;
    if (v < -MAX_STEP) return -MAX_STEP;
    return v;
  endfunction

  // mask bits: 0 up, 1 down, 2 left, 3 right, 5 clear (confirm handled separately)
  task automatic model_press(input logic [5:0] m);
    if (m[5]) begin
      mx = 0; my = 0;
    end else begin
      mx = clamp(mx + int'(m[3]) - int'(m[2]));
      my = clamp(my + int'(m[1]) - int'(m[0]));
    end
  endtask

  task automatic press(input logic [5:0] m);
    {btn_clear, btn_confirm, btn_right, btn_left, btn_down, btn_up} = m;
    @(posedge clk); #1;
    {btn_clear, btn_confirm, btn_right, btn_left, btn_down, btn_up} = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic press_and_model(input logic [5:0] m);
    press(m);
    model_press(m);
  endtask

  task automatic commit_move(input int hold, input string nm);
    int n0, n1, got, other;
    logic [4:0] ex, ey;
    n0 = n_en0; n1 = n_en1;
    ex = mx[4:0]; ey = my[4:0];
    btn_confirm = 1'b1;
    repeat (hold) @(posedge clk);
    #1 btn_confirm = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    got   = mturn ? n_en1 - n1 : n_en0 - n0;
    other = mturn ? n_en0 - n0 : n_en1 - n1;
    n_tests++;
    if (got !== 1) begin
      n_fail++; $display("FAIL %s enable pulses: got %0d want 1", nm, got);
    end
    n_tests++;
    if (other !== 0) begin
      n_fail++; $display("FAIL %s other enable pulses: got %0d want 0", nm, other);
    end
    n_tests++;
    if (cap_x !== ex || cap_y !== ey || cap_busy !== 1'b1 || cap_to !== 1'b0) begin
      n_fail++;
      $display("FAIL %s issued vector: got x=%b y=%b busy=%b to=%b want x=%b y=%b busy=1 to=0",
               nm, cap_x, cap_y, cap_busy, cap_to, ex, ey);
    end
    mturn = ~mturn; mcount = (mcount + 1) % 256; mx = 0; my = 0;
    n_tests++;
    if (turn !== mturn || turn_count !== 8'(mcount) || xMove !== 5'd0 || yMove !== 5'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after commit: got turn=%b count=%0d x=%b y=%b busy=%b want turn=%b count=%0d x=0 y=0 busy=0",
               nm, turn, turn_count, xMove, yMove, busy, mturn, mcount);
    end
  endtask

  task automatic check_vec(input string nm);
    logic [4:0] ex, ey;
    ex = mx[4:0]; ey = my[4:0];
    n_tests++;
    if (xMove !== ex || yMove !== ey) begin
      n_fail++; $display("FAIL %s vector: got x=%b y=%b want x=%b y=%b", nm, xMove, yMove, ex, ey);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (xMove !== 5'd0 || yMove !== 5'd0 || en0 !== 1'b0 || en1 !== 1'b0 || turn !== 1'b0 ||
        busy !== 1'b0 || turn_count !== 8'd0 || timed_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset state: got x=%b y=%b en0=%b en1=%b turn=%b busy=%b count=%0d to=%b want all zero",
               xMove, yMove, en0, en1, turn, busy, turn_count, timed_out);
    end
    rst = 1'b1;
    mx = 0; my = 0; mturn = 0; mcount = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_issue();
    press_and_model(6'b001000);
    btn_confirm = 1'b1;
    @(posedge clk); #1 btn_confirm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (en0 !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid-issue entry: got en0=%b busy=%b want 1 1", en0, busy);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (en0 !== 1'b0 || en1 !== 1'b0 || turn !== 1'b0 || turn_count !== 8'd0 || busy !== 1'b0 || xMove !== 5'd0) begin
      n_fail++;
      $display("FAIL async reset in issue: got en0=%b en1=%b turn=%b count=%0d busy=%b x=%b want 0 0 0 0 0 0",
               en0, en1, turn, turn_count, busy, xMove);
    end
    @(posedge clk); #1 rst = 1'b1;
    mx = 0; my = 0; mturn = 0; mcount = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed_move();
    press_and_model(6'b001000);
    press_and_model(6'b001000);
    press_and_model(6'b000001);
    n_tests++;
    if (xMove !== 5'b00010 || yMove !== 5'b11111) begin
      n_fail++; $display("FAIL directed vector: got x=%b y=%b want 00010 11111", xMove, yMove);
    end
    commit_move(1, "directed_commit");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) press_and_model(6'b000100);
    n_tests++;
    if (xMove !== 5'b11101) begin
      n_fail++; $display("FAIL saturate low: got x=%b want 11101", xMove);
    end
    press_and_model(6'b001000);
    n_tests++;
    if (xMove !== 5'b11110) begin
      n_fail++; $display("FAIL back off saturation: got x=%b want 11110", xMove);
    end
    for (int i = 0; i < 5; i++) press_and_model(6'b000010);
    n_tests++;
    if (yMove !== 5'b00011) begin
      n_fail++; $display("FAIL saturate high: got y=%b want 00011", yMove);
    end
  endtask

  task automatic test_cancel();
    press_and_model(6'b000011);
    n_tests++;
    if (yMove !== 5'b00011) begin
      n_fail++; $display("FAIL up+down cancel: got y=%b want 00011", yMove);
    end
    press_and_model(6'b001100);
    check_vec("left_right_cancel");
  endtask

  task automatic test_clear_priority();
    press_and_model(6'b101000);
    n_tests++;
    if (xMove !== 5'd0 || yMove !== 5'd0) begin
      n_fail++; $display("FAIL clear with right: got x=%b y=%b want 0 0", xMove, yMove);
    end
  endtask

  task automatic test_confirm_held();
    press_and_model(6'b000010);
    commit_move(20, "held_confirm");
  endtask

  task automatic test_pass_move();
    commit_move(1, "pass_move");
  endtask

  task automatic test_busy_ignore();
    btn_confirm = 1'b1;
    @(posedge clk); #1 btn_confirm = 1'b0; btn_right = 1'b1;
    @(posedge clk); #1 btn_right = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy during issue: got %b want 1", busy);
    end
    repeat (5) @(posedge clk);
    #1;
    mturn = ~mturn; mcount = (mcount + 1) % 256;
    n_tests++;
    if (xMove !== 5'd0 || turn !== mturn || turn_count !== 8'(mcount)) begin
      n_fail++;
      $display("FAIL edge during busy: got x=%b turn=%b count=%0d want x=0 turn=%b count=%0d",
               xMove, turn, turn_count, mturn, mcount);
    end
  endtask

  task automatic test_random();
    logic [5:0] m;
    for (int t = 0; t < 8; t++) begin
      for (int p = 0; p < int'($urandom_range(1, 7)); p++) begin
        m = {($urandom_range(0, 7) == 0), 1'b0, 4'($urandom_range(0, 15))};
        press_and_model(m);
        check_vec("random_press");
      end
      commit_move(int'($urandom_range(1, 4)), "random_commit");
    end
  endtask

`ifdef TURN_TIMEOUT_EN
  task automatic test_timeout();
    int hit;
    hit = -1;
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 1; i <= 40 && hit < 0; i++) begin
      @(posedge clk); #1;
      if (en0) begin
        hit = i;
        n_tests++;
        if (timed_out !== 1'b1 || yMove !== 5'b00001 || xMove !== 5'd0) begin
          n_fail++;
          $display("FAIL timeout issue: got to=%b x=%b y=%b want to=1 x=0 y=00001", timed_out, xMove, yMove);
        end
      end
      btn_down = (i == 1);
    end
    n_tests++;
    if (hit !== 16) begin
      n_fail++; $display("FAIL timeout latency: got %0d want 16", hit);
    end
    @(posedge clk); #1;
    n_tests++;
    if (timed_out !== 1'b0) begin
      n_fail++; $display("FAIL timeout pulse width: got to=%b want 0", timed_out);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef TURN_TIMEOUT_EN
    test_timeout();
`else
    test_reset_mid_issue();
    test_directed_move();
    test_saturation();
    test_cancel();
    test_clear_priority();
    test_confirm_held();
    test_pass_move();
    test_busy_ignore();
    test_random();
`endif
    n_tests++;
    if (n_both !== 0) begin
      n_fail++; $display("FAIL both enables high: got %0d cycles want 0", n_both);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
